// File: rtl/ldo_seq_ctrl.sv
// LDO power sequencer: ordered enable, power-good watch, ordered disable.
// Ports: wb_clk_i/wb_rst_i, start_i/stop_i/clr_i commands, ch_mask_i/dly_i
// config, pg_i raw power-good; en_o, state_o, fault_o, fault_ch_o, irq_o.
module ldo_seq_ctrl #(
  parameter int N_CH  = 3,
  parameter int CNT_W = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            start_i,
  input  logic            stop_i,
  input  logic            clr_i,
  input  logic [N_CH-1:0] ch_mask_i,
  input  logic [CNT_W-1:0] dly_i,
  input  logic [N_CH-1:0] pg_i,
  output logic [N_CH-1:0] en_o,
  output logic [2:0]      state_o,
  output logic            fault_o,
  output logic [2:0]      fault_ch_o,
  output logic            irq_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_UP    = 3'd1,
    S_ON    = 3'd2,
    S_DOWN  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t            r_state;
  logic [N_CH-1:0]   r_en;
  logic [N_CH-1:0]   r_cur;
  logic [N_CH-1:0]   r_mask;
  logic [CNT_W-1:0]  r_dly;
  logic [CNT_W-1:0]  r_cnt;
  logic [N_CH-1:0]   r_pg_meta;
  logic [N_CH-1:0]   r_pg_s;
  logic              r_fault;
  logic [2:0]        r_fault_ch;
  logic              r_irq;

  logic [CNT_W-1:0]  w_dly_in;
  logic [CNT_W-1:0]  w_dly_lat;
  logic              w_tc;
  logic [N_CH-1:0]   w_first;
  logic [N_CH-1:0]   w_pend;
  logic [N_CH-1:0]   w_nxt;
  logic [N_CH-1:0]   w_top;
  logic [N_CH-1:0]   w_drop;
  logic              w_tmo;

  // One-hot of the lowest set bit.
  function automatic logic [N_CH-1:0] f_lo(
    input logic [N_CH-1:0] v
  );
    f_lo = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (v[i]) f_lo = N_CH'(1) << i;
  endfunction

  // One-hot of the highest set bit.
  function automatic logic [N_CH-1:0] f_hi(
    input logic [N_CH-1:0] v
  );
    f_hi = '0;
    for (int i = 0; i < N_CH; i++)
      if (v[i]) f_hi = N_CH'(1) << i;
  endfunction

  function automatic logic [2:0] f_idx(
    input logic [N_CH-1:0] v
  );
    f_idx = '0;
    for (int i = 0; i < N_CH; i++)
      if (v[i]) f_idx = 3'(i);
  endfunction

  // A zero delay still spends one cycle per step.
  assign w_dly_in  = (dly_i == '0) ? CNT_W'(1) : dly_i;
  assign w_dly_lat = (r_dly == '0) ? CNT_W'(1) : r_dly;
  assign w_tc      = (r_cnt <= CNT_W'(1));
  assign w_first   = f_lo(ch_mask_i);
  assign w_pend    = r_mask & ~r_en;
  assign w_nxt     = f_lo(w_pend);
  assign w_top     = f_hi(r_en);
  assign w_drop    = r_en & ~r_pg_s;
  assign w_tmo     = |(r_cur & ~r_pg_s);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state    <= S_IDLE;
      r_en       <= '0;
      r_cur      <= '0;
      r_mask     <= '0;
      r_dly      <= '0;
      r_cnt      <= '0;
      r_pg_meta  <= '0;
      r_pg_s     <= '0;
      r_fault    <= 1'b0;
      r_fault_ch <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_pg_meta <= pg_i;
      r_pg_s    <= r_pg_meta;
      r_irq     <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          // Stop wins over a same-cycle start; stop is a no-op here.
          if (start_i && !stop_i && |ch_mask_i) begin
            r_mask  <= ch_mask_i;
            r_dly   <= dly_i;
            r_cur   <= w_first;
            r_en    <= w_first;
            r_cnt   <= w_dly_in;
            r_state <= S_UP;
          end
        end
        S_UP: begin
          if (w_tc && w_tmo) begin
            r_en       <= '0;
            r_fault    <= 1'b1;
            r_fault_ch <= f_idx(r_cur);
            r_irq      <= 1'b1;
            r_state    <= S_FAULT;
          end else if (stop_i) begin
            r_en    <= r_en & ~w_top;
            r_cnt   <= w_dly_lat;
            r_state <= S_DOWN;
          end else if (w_tc) begin
            if (|w_pend) begin
              r_cur <= w_nxt;
              r_en  <= r_en | w_nxt;
              r_cnt <= w_dly_lat;
            end else begin
              r_irq   <= 1'b1;
              r_state <= S_ON;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_ON: begin
          if (|w_drop) begin
            r_en       <= '0;
            r_fault    <= 1'b1;
            r_fault_ch <= f_idx(f_lo(w_drop));
            r_irq      <= 1'b1;
            r_state    <= S_FAULT;
          end else if (stop_i) begin
            r_en    <= r_en & ~w_top;
            r_cnt   <= w_dly_lat;
            r_state <= S_DOWN;
          end
        end
        S_DOWN: begin
          if (r_en == '0) begin
            r_state <= S_IDLE;
          end else if (w_tc) begin
            r_en  <= r_en & ~w_top;
            r_cnt <= w_dly_lat;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_FAULT: begin
          if (clr_i) begin
            r_fault    <= 1'b0;
            r_fault_ch <= '0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign en_o       = r_en;
  assign state_o    = r_state;
  assign fault_o    = r_fault;
  assign fault_ch_o = r_fault_ch;
  assign irq_o      = r_irq;

endmodule

// File: tb/tb_ldo_seq_ctrl.sv
// Bench for ldo_seq_ctrl: directed sequences plus random commands,
// checked every cycle against a timeline-based behavioural model.
module tb_ldo_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        clr_i = 1'b0;
  logic [2:0]  ch_mask_i = '0;
  logic [15:0] dly_i = '0;
  logic [2:0]  pg_i = '0;
  logic [2:0]  en_o;
  logic [2:0]  state_o;
  logic        fault_o;
  logic [2:0]  fault_ch_o;
  logic        irq_o;

  int n_chk = 0;
  int n_err = 0;
  int n_irq = 0;

  // pg_i follows the expected enables, gated by which LDOs are healthy.
  logic [2:0] ok = 3'b111;

  int         m_st;
  logic [2:0] m_en;
  logic       m_fault;
  logic [2:0] m_fch;
  logic       m_irq;
  int         m_due;
  int         m_dly1;
  int         m_cur;
  int         cyc_no;
  logic [2:0] m_pg1, m_pg2;
  int         m_upq[$];

  ldo_seq_ctrl dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .clr_i      (clr_i),
    .ch_mask_i  (ch_mask_i),
    .dly_i      (dly_i),
    .pg_i       (pg_i),
    .en_o       (en_o),
    .state_o    (state_o),
    .fault_o    (fault_o),
    .fault_ch_o (fault_ch_o),
    .irq_o      (irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [2:0] v);
    for (int k = 0; k < 3; k++) if (v[k]) return k;
    return 0;
  endfunction

  function automatic int highest(input logic [2:0] v);
    for (int k = 2; k >= 0; k--) if (v[k]) return k;
    return 0;
  endfunction

  task automatic model_reset();
    m_st = 0; m_en = '0; m_fault = 0; m_fch = '0; m_irq = 0;
    m_pg1 = '0; m_pg2 = '0; m_upq = {};
  endtask

  task automatic go_fault(input int k);
    m_en = '0; m_fault = 1; m_fch = 3'(k); m_irq = 1; m_st = 4;
  endtask

  task automatic go_down();
    m_en[highest(m_en)] = 1'b0;
    m_due = cyc_no + m_dly1;
    m_st = 3;
  endtask

  // One clock edge of the spec behaviour, in absolute-cycle terms.
  task automatic model_step();
    logic [2:0] drop;
    drop = m_en & ~m_pg2;
    m_irq = 0;
    cyc_no++;
    case (m_st)
      0: if (start_i && !stop_i && ch_mask_i != 0) begin
        m_dly1 = (dly_i == 0) ? 1 : int'(dly_i);
        m_upq = {};
        for (int k = 0; k < 3; k++) if (ch_mask_i[k]) m_upq.push_back(k);
        m_cur = m_upq.pop_front();
        m_en[m_cur] = 1'b1;
        m_due = cyc_no + m_dly1;
        m_st = 1;
      end
      1: begin
        if (cyc_no == m_due && !m_pg2[m_cur]) go_fault(m_cur);
        else if (stop_i) go_down();
        else if (cyc_no == m_due) begin
          if (m_upq.size() > 0) begin
            m_cur = m_upq.pop_front();
            m_en[m_cur] = 1'b1;
            m_due = cyc_no + m_dly1;
          end else begin
            m_st = 2; m_irq = 1;
          end
        end
      end
      2: if (drop != 0) go_fault(lowest(drop));
         else if (stop_i) go_down();
      3: if (m_en == 0) m_st = 0;
         else if (cyc_no == m_due) begin
           m_en[highest(m_en)] = 1'b0;
           m_due = cyc_no + m_dly1;
         end
      4: if (clr_i) begin m_st = 0; m_fault = 0; m_fch = '0; end
      default: m_st = 0;
    endcase
    m_pg2 = m_pg1;
    m_pg1 = pg_i;
  endtask

  task automatic cmp_all();
    chk("en", 32'(en_o), 32'(m_en));
    chk("state", 32'(state_o), 32'(m_st));
    chk("fault", 32'(fault_o), 32'(m_fault));
    chk("fault_ch", 32'(fault_ch_o), 32'(m_fch));
    chk("irq", 32'(irq_o), 32'(m_irq));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    cmp_all();
    if (irq_o) n_irq++;
    pg_i = m_en & ok;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic cmd_start(input logic [2:0] msk, input int d);
    ch_mask_i = msk; dly_i = 16'(d);
    start_i = 1; run(1); start_i = 0;
  endtask

  initial begin
    cyc_no = 0;
    model_reset();
    #1;
    chk("rst_en", 32'(en_o), 0);
    chk("rst_state", 32'(state_o), 0);
    chk("rst_fault", 32'(fault_o), 0);
    run(3);
    #3 rst = 0;

    // Power-up 111, dly 4
    n_irq = 0;
    cmd_start(3'b111, 4);
    chk("up1_en", 32'(en_o), 32'h1);
    run(4);
    chk("up2_en", 32'(en_o), 32'h3);
    run(4);
    chk("up3_en", 32'(en_o), 32'h7);
    run(4);
    chk("on_state", 32'(state_o), 2);
    chk("on_irq", 32'(irq_o), 1);
    run(3);
    chk("irq_cnt", n_irq, 1);

    // Power-down
    stop_i = 1; run(1); stop_i = 0;
    chk("dn1_en", 32'(en_o), 32'h3);
    run(4);
    chk("dn2_en", 32'(en_o), 32'h1);
    run(4);
    chk("dn3_en", 32'(en_o), 32'h0);
    run(1);
    chk("dn_idle", 32'(state_o), 0);

    // Timeout on channel 2
    ok = 3'b011;
    cmd_start(3'b101, 3);
    run(6);
    chk("tmo_state", 32'(state_o), 4);
    chk("tmo_ch", 32'(fault_ch_o), 2);
    chk("tmo_en", 32'(en_o), 0);
    chk("tmo_irq", 32'(irq_o), 1);
    start_i = 1; stop_i = 1; run(2); start_i = 0; stop_i = 0;
    chk("flt_hold", 32'(state_o), 4);
    clr_i = 1; run(1); clr_i = 0;
    chk("clr_state", 32'(state_o), 0);
    chk("clr_fault", 32'(fault_o), 0);

    // Run fault on channel 1
    ok = 3'b111;
    cmd_start(3'b111, 3);
    run(11);
    chk("rf_on", 32'(state_o), 2);
    ok = 3'b101; pg_i = m_en & ok;
    run(3);
    chk("rf_state", 32'(state_o), 4);
    chk("rf_ch", 32'(fault_ch_o), 1);
    clr_i = 1; run(1); clr_i = 0; ok = 3'b111;

    // dly=0 acts as 1: pg cannot arrive through the sync in time
    cmd_start(3'b001, 0);
    run(1);
    chk("d0_state", 32'(state_o), 4);
    chk("d0_ch", 32'(fault_ch_o), 0);
    clr_i = 1; run(1); clr_i = 0;

    // Empty mask ignored
    cmd_start(3'b000, 2);
    run(2);
    chk("m0_state", 32'(state_o), 0);

    // start+stop together in ON -> DOWN
    cmd_start(3'b011, 3);
    run(6);
    start_i = 1; stop_i = 1; run(1); start_i = 0; stop_i = 0;
    chk("ss_state", 32'(state_o), 3);
    chk("ss_en", 32'(en_o), 32'h1);
    run(4);
    chk("ss_idle", 32'(state_o), 0);

    // Reset in the middle of power-up
    cmd_start(3'b111, 5);
    run(7);
    chk("mr_pre", 32'(en_o), 32'h3);
    #3 rst = 1;
    #1;
    model_reset();
    pg_i = '0;
    cmp_all();
    run(2);
    ch_mask_i = 3'b111; start_i = 1;
    #3 rst = 0;
    #1 chk("mr_rel", 32'(state_o), 0);
    run(1); start_i = 0;
    chk("mr_up", 32'(state_o), 1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      start_i = ($urandom_range(0, 19) == 0);
      stop_i = ($urandom_range(0, 39) == 0);
      clr_i = ($urandom_range(0, 14) == 0);
      ch_mask_i = 3'($urandom_range(0, 7));
      dly_i = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 59) == 0) begin
        ok = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
        pg_i = m_en & ok;
      end
      run(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
